// File: rtl/stream_argcmp.sv
// stream_argcmp: sequential arg-max / arg-min scanner over a stream of
// candidates. One candidate is accepted per cycle. The scanner reports the best
// value, the index of that value, a tie flag, the number of candidates and a
// flag that shows when the scan was cut off at full capacity.
module stream_argcmp #(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 5,
  parameter int SIGNED   = 0,
  parameter int TIE_LAST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_tie,
  output logic             out_trunc,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Capacity of one scan: 2**IDX_W candidates. The count is one bit wider so
  // that this value can be held.
  localparam logic [IDX_W:0] CAP = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             tie_q, tie_d;
  logic             trunc_q, trunc_d;

  logic             accept;
  logic [IDX_W:0]   cnt_inc;
  logic             cand_better;
  logic             cand_equal;

  // Returns 1 when the candidate is strictly better than the current best.
  // The scan direction (max or min) selects which test applies. The SIGNED
  // parameter selects the number format of the compare.
  function automatic logic is_better(input logic [WIDTH-1:0] cand,
                                     input logic [WIDTH-1:0] best,
                                     input logic             find_min);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(cand) > $signed(best);
      lt = $signed(cand) < $signed(best);
    end else begin
      gt = cand > best;
      lt = cand < best;
    end
    return find_min ? lt : gt;
  endfunction

  assign accept      = in_valid && (state_q == S_SCAN);
  assign cnt_inc     = cnt_q + ONE;
  assign cand_better = is_better(in_data, best_q, mode_q);
  assign cand_equal  = (in_data == best_q);

  // Next-state and result-register update logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tie_d   = tie_q;
    trunc_d = trunc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          tie_d   = 1'b0;
          trunc_d = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            // The first candidate is the best by definition.
            best_d = in_data;
            idx_d  = '0;
            tie_d  = 1'b0;
          end else if (cand_better) begin
            best_d = in_data;
            idx_d  = cnt_q[IDX_W-1:0];
            tie_d  = 1'b0;
          end else if (cand_equal) begin
            tie_d = 1'b1;
            if (TIE_LAST != 0) begin
              idx_d = cnt_q[IDX_W-1:0];
            end
          end

          // in_last has priority over the capacity cut-off, so a scan that
          // ends exactly at capacity is not marked as truncated.
          if (in_last) begin
            trunc_d = 1'b0;
            state_d = S_DONE;
          end else if (cnt_inc == CAP) begin
            trunc_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers. All are cleared on reset so that every
  // output reads 0 while reset is asserted and after it is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tie_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tie_q   <= tie_d;
      trunc_q <= trunc_d;
    end
  end

  assign in_ready  = (state_q == S_SCAN);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = best_q;
  assign out_idx   = idx_q;
  assign out_count = cnt_q;
  assign out_tie   = tie_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_stream_argcmp.sv
// Directed bench for stream_argcmp. Four instances share one stimulus:
// the default configuration, TIE_LAST=1, SIGNED=1 and IDX_W=2.
module tb_stream_argcmp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default configuration
  logic        b_in_ready, b_out_valid, b_out_tie, b_out_trunc, b_busy;
  logic [15:0] b_out_data;
  logic [4:0]  b_out_idx;
  logic [5:0]  b_out_count;
  // TIE_LAST = 1
  logic        t_in_ready, t_out_valid, t_out_tie, t_out_trunc, t_busy;
  logic [15:0] t_out_data;
  logic [4:0]  t_out_idx;
  logic [5:0]  t_out_count;
  // SIGNED = 1
  logic        s_in_ready, s_out_valid, s_out_tie, s_out_trunc, s_busy;
  logic [15:0] s_out_data;
  logic [4:0]  s_out_idx;
  logic [5:0]  s_out_count;
  // IDX_W = 2
  logic        o_in_ready, o_out_valid, o_out_tie, o_out_trunc, o_busy;
  logic [15:0] o_out_data;
  logic [1:0]  o_out_idx;
  logic [2:0]  o_out_count;

  stream_argcmp #(.WIDTH(16), .IDX_W(5), .SIGNED(0), .TIE_LAST(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_count(b_out_count), .out_tie(b_out_tie),
    .out_trunc(b_out_trunc), .busy(b_busy));

  stream_argcmp #(.WIDTH(16), .IDX_W(5), .SIGNED(0), .TIE_LAST(1)) u_t (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .out_idx(t_out_idx), .out_count(t_out_count), .out_tie(t_out_tie),
    .out_trunc(t_out_trunc), .busy(t_busy));

  stream_argcmp #(.WIDTH(16), .IDX_W(5), .SIGNED(1), .TIE_LAST(0)) u_s (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .out_count(s_out_count), .out_tie(s_out_tie),
    .out_trunc(s_out_trunc), .busy(s_busy));

  stream_argcmp #(.WIDTH(16), .IDX_W(2), .SIGNED(0), .TIE_LAST(0)) u_o (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
    .out_idx(o_out_idx), .out_count(o_out_count), .out_tie(o_out_tie),
    .out_trunc(o_out_trunc), .busy(o_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_b_zero(input string tag);
    chk({tag, "_in_ready"},  {31'd0, b_in_ready},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, b_out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, b_busy},      32'd0);
    chk({tag, "_data"},      {16'd0, b_out_data},  32'd0);
    chk({tag, "_idx"},       {27'd0, b_out_idx},   32'd0);
    chk({tag, "_count"},     {26'd0, b_out_count}, 32'd0);
    chk({tag, "_tie"},       {31'd0, b_out_tie},   32'd0);
    chk({tag, "_trunc"},     {31'd0, b_out_trunc}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk_b_zero("rst0");
    chk("rst0_o_valid", {31'd0, o_out_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_b_zero("rst0_rel");

    // Test 1: max, unsigned, with an input gap and an ignored start during the scan
    do_start(1'b0);
    chk("t1_busy", {31'd0, b_busy}, 32'd1);
    chk("t1_in_ready", {31'd0, b_in_ready}, 32'd1);
    send(16'h0010, 1'b0);
    send(16'h00A0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t1_gap_valid", {31'd0, b_out_valid}, 32'd0);
    chk("t1_gap_busy", {31'd0, b_busy}, 32'd1);
    send(16'h0003, 1'b0);
    send(16'h00A0, 1'b1);
    chk("t1_b_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t1_b_data", {16'd0, b_out_data}, 32'h00A0);
    chk("t1_b_idx", {27'd0, b_out_idx}, 32'd1);
    chk("t1_b_tie", {31'd0, b_out_tie}, 32'd1);
    chk("t1_b_count", {26'd0, b_out_count}, 32'd4);
    chk("t1_b_trunc", {31'd0, b_out_trunc}, 32'd0);
    chk("t1_t_idx", {27'd0, t_out_idx}, 32'd3);
    chk("t1_t_tie", {31'd0, t_out_tie}, 32'd1);
    chk("t1_o_count", {29'd0, o_out_count}, 32'd4);
    chk("t1_o_trunc_lastwins", {31'd0, o_out_trunc}, 32'd0);
    chk("t1_o_idx", {30'd0, o_out_idx}, 32'd1);
    // Consumer stalls for 5 cycles while in_valid is offered in DONE
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("t1_hold_valid", {31'd0, b_out_valid}, 32'd1);
      chk("t1_hold_data", {16'd0, b_out_data}, 32'h00A0);
      chk("t1_hold_in_ready", {31'd0, b_in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("t1_hold_count", {26'd0, b_out_count}, 32'd4);
    chk("t1_hold_idx", {27'd0, b_out_idx}, 32'd1);
    handshake();
    chk("t1_post_valid", {31'd0, b_out_valid}, 32'd0);
    chk("t1_post_busy", {31'd0, b_busy}, 32'd0);
    chk("t1_post_data_kept", {16'd0, b_out_data}, 32'h00A0);

    // Test 2: min on the same stream, started on the first IDLE cycle
    do_start(1'b1);
    send(16'h0010, 1'b0);
    send(16'h00A0, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h00A0, 1'b1);
    chk("t2_b_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t2_b_data", {16'd0, b_out_data}, 32'h0003);
    chk("t2_b_idx", {27'd0, b_out_idx}, 32'd2);
    chk("t2_b_tie", {31'd0, b_out_tie}, 32'd0);
    chk("t2_b_count", {26'd0, b_out_count}, 32'd4);
    handshake();

    // Test 3: signed versus unsigned min
    do_start(1'b1);
    send(16'h0005, 1'b0);
    send(16'hFFFE, 1'b1);
    chk("t3_s_data", {16'd0, s_out_data}, 32'hFFFE);
    chk("t3_s_idx", {27'd0, s_out_idx}, 32'd1);
    chk("t3_b_data", {16'd0, b_out_data}, 32'h0005);
    chk("t3_b_idx", {27'd0, b_out_idx}, 32'd0);
    chk("t3_b_count", {26'd0, b_out_count}, 32'd2);
    chk("t3_b_tie", {31'd0, b_out_tie}, 32'd0);
    handshake();

    // Test 4: capacity overflow on the IDX_W=2 instance
    do_start(1'b0);
    send(16'd7, 1'b0);
    send(16'd9, 1'b0);
    send(16'd2, 1'b0);
    send(16'd9, 1'b0);
    chk("t4_o_valid", {31'd0, o_out_valid}, 32'd1);
    chk("t4_o_trunc", {31'd0, o_out_trunc}, 32'd1);
    chk("t4_o_count", {29'd0, o_out_count}, 32'd4);
    chk("t4_o_data", {16'd0, o_out_data}, 32'd9);
    chk("t4_o_idx", {30'd0, o_out_idx}, 32'd1);
    chk("t4_o_tie", {31'd0, o_out_tie}, 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h0050;
    chk("t4_o_in_ready", {31'd0, o_in_ready}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("t4_o_count_after", {29'd0, o_out_count}, 32'd4);
    chk("t4_o_data_after", {16'd0, o_out_data}, 32'd9);
    chk("t4_b_count", {26'd0, b_out_count}, 32'd5);
    rst = 1'b1;
    #1;
    chk("t4_rst_o_valid", {31'd0, o_out_valid}, 32'd0);
    chk("t4_rst_o_trunc", {31'd0, o_out_trunc}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Test 5: reset in the middle of a scan, then a single-candidate scan
    do_start(1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    rst = 1'b1;
    #1;
    chk_b_zero("t5_rst");
    step();
    rst = 1'b0;
    step();
    step();
    chk("t5_no_valid", {31'd0, b_out_valid}, 32'd0);
    chk("t5_idle", {31'd0, b_busy}, 32'd0);
    do_start(1'b0);
    send(16'h1234, 1'b1);
    chk("t5_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t5_data", {16'd0, b_out_data}, 32'h1234);
    chk("t5_idx", {27'd0, b_out_idx}, 32'd0);
    chk("t5_count", {26'd0, b_out_count}, 32'd1);
    chk("t5_tie", {31'd0, b_out_tie}, 32'd0);
    chk("t5_trunc", {31'd0, b_out_trunc}, 32'd0);
    handshake();
    chk("t5_post_valid", {31'd0, b_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_argcmp.md
Name: stream_argcmp

Overview:
- Parametrised, sequential successor to the team's fixed 16-bit three-way comparator.
- Scans a stream of N candidate values (e.g. Q-values of neighbour nodes) and returns the best value, its index, a tie flag and the candidate count.
- Best is the maximum or the minimum, selectable per scan.
- Sits between the Q-table read path and the next-hop selection logic, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, bit width of each candidate value.
- IDX_W, 5, index/count width; at most 2**IDX_W candidates per scan.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- TIE_LAST, 0, 0 = first-seen of equal bests wins, 1 = last-seen wins.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- mode  in  1  latched at start: 0 = find max, 1 = find min.
- in_valid  in  1  candidate valid.
- in_ready  out  1  block accepts a candidate.
- in_data  in  WIDTH  candidate value.
- in_last  in  1  final candidate of the scan.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  best value.
- out_idx  out  IDX_W  index of the best value, 0-based, in arrival order.
- out_count  out  IDX_W+1  number of candidates accepted.
- out_tie  out  1  at least one other candidate equalled the final best.
- out_trunc  out  1  scan ended on capacity overflow, not on in_last.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0 while rst is asserted and after release: in_ready, out_valid, busy, out_data, out_idx, out_count, out_tie, out_trunc.
  - Reset mid-scan or mid-DONE discards the partial result; no out_valid follows.
- FSM:
  - IDLE:
    - in_ready = 0.
    - When start = 1: latch mode, clear count/tie/trunc, go to SCAN next cycle.
    - start is ignored in all other states.
  - SCAN:
    - in_ready = 1.
    - An accept is in_valid & in_ready.
    - First accept loads best = in_data, idx = 0, tie = 0.
    - Later accepts compare in_data against best using the latched mode and SIGNED.
    - Strictly better: best = in_data, idx = count, tie = 0.
    - Equal: tie = 1; idx updates to count only if TIE_LAST = 1.
    - Worse: no change to best, idx or tie.
    - count increments on every accept.
    - An accept with in_last = 1 goes to DONE.
    - The accept that brings count to 2**IDX_W with in_last = 0 goes to DONE with trunc = 1.
    - Candidates with in_valid = 0 stall the scan indefinitely.
  - DONE:
    - out_valid = 1; in_ready = 0.
    - Outputs hold stable until out_ready = 1.
    - On out_valid & out_ready, go to IDLE next cycle; out_valid deasserts.
    - Result registers keep their values after the handshake; only out_valid clears.
- Latency and throughput:
  - One candidate per cycle.
  - out_valid rises on the cycle after the last accept.
  - Minimum scan of 1 candidate: start (cycle 0), accept (cycle 1), out_valid (cycle 2).
  - Back-to-back: start may be asserted on the first IDLE cycle after the handshake.
- Arithmetic:
  - The compare is a full WIDTH-bit magnitude compare; no saturation or truncation of data.
  - count is IDX_W+1 bits so that 2**IDX_W is representable.
  - out_idx never exceeds 2**IDX_W − 1.
- Boundary conditions:
  - A single-candidate scan gives idx = 0, count = 1, tie = 0.
  - out_tie refers to the final best only. It clears whenever a strictly better value replaces the best.
  - in_last together with the capacity-reaching accept gives trunc = 0, because in_last wins.
  - in_valid asserted in IDLE or DONE is not consumed.

Test Plan:
- Max, unsigned, WIDTH 16: start mode=0; stream 0x0010, 0x00A0, 0x0003, 0x00A0(last) -> out_data 0x00A0, out_idx 1, out_tie 1, out_count 4, out_trunc 0.
- Same stream with TIE_LAST=1 -> out_idx 3; same stream with mode=1 -> out_data 0x0003, out_idx 2, out_tie 0.
- SIGNED=1, min: stream 0x0005, 0xFFFE(last) -> out_data 0xFFFE (−2), out_idx 1. SIGNED=0 on the same stream, min -> out_data 0x0005, out_idx 0.
- Overflow with IDX_W=2: 4 accepts 7, 9, 2, 9, none with in_last -> out_trunc 1, out_count 4, out_data 9, out_idx 1, out_tie 1. A 5th in_valid is not accepted (in_ready 0).
- Handshake stalls:
  - in_valid gaps mid-scan -> no spurious accepts.
  - out_ready held low 5 cycles -> outputs stable; out_valid for 5 cycles, then drops 1 cycle after out_ready.
  - start asserted during SCAN is ignored.
- Reset mid-scan: rst pulsed after 2 accepts -> all outputs 0 immediately. A new scan of a single value 0x1234(last) gives out_data 0x1234, out_idx 0, out_count 1.
